// File: rtl/barret_2137_arbiter_if.sv
// Request/response bundle for the shared mod-2137 reducer.
// The slave side is the arbiter; the master side is its environment.
interface barret_2137_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*23-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [11:0]           rsp_data;
  logic                  rsp_ready;
  logic                  busy;

  modport master (
    output req_valid,
    output req_data,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_data,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_id,
    output rsp_data,
    output busy
  );
endinterface

// File: rtl/barret_2137_arbiter.sv
// Round-robin arbiter in front of a 2-stage Barrett reducer, mod 2137.
// One grant per cycle; tagged results leave in acceptance order.
module barret_2137_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int Q       = 2137,
  parameter int MU      = 7850
) (
  input  logic                 clk,
  input  logic                 rst,
  barret_2137_arbiter_if.slave bus
);

  localparam int SW = ID_W + 1;

  logic [ID_W-1:0] ptr_q, ptr_d;

  logic            s1_valid_q, s1_valid_d;
  logic [22:0]     s1_x_q, s1_x_d;
  logic [11:0]     s1_q3_q, s1_q3_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [11:0]     rsp_data_q, rsp_data_d;

  logic            adv;
  logic            accept;
  logic            gnt_found;
  logic [ID_W-1:0] gnt_id;
  logic [22:0]     gnt_data;
  logic [SW-1:0]   sum;

  logic [11:0]     q1;
  logic [24:0]     q2;
  logic [11:0]     q3;
  logic [23:0]     q3q;
  logic [12:0]     r;
  logic [12:0]     r_sub;
  logic [11:0]     red;

  // Whole pipeline moves only when the output slot is free or leaving.
  always_comb begin
    adv    = !rsp_valid_q || bus.rsp_ready;
    accept = adv && !rst && gnt_found;
  end

  // Rotating first-valid search starting at the pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    sum       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + SW'(k);
      if (sum >= SW'(NUM_REQ))
        sum = sum - SW'(NUM_REQ);
      if (!gnt_found && bus.req_valid[sum[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = sum[ID_W-1:0];
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_id == ID_W'(k))
        gnt_data = bus.req_data[23*k +: 23];
    end
  end

  // One-hot ready for the winner, and pointer moves past it.
  always_comb begin
    bus.req_ready = '0;
    ptr_d         = ptr_q;
    if (accept) begin
      bus.req_ready = NUM_REQ'(1) << gnt_id;
      if (gnt_id == ID_W'(NUM_REQ - 1))
        ptr_d = '0;
      else
        ptr_d = gnt_id + 1'b1;
    end
  end

  // Quotient estimate: (x>>11)*MU>>13, product kept untruncated.
  always_comb begin
    q1 = gnt_data[22:11];
    q2 = {13'b0, q1} * 25'(MU);
    q3 = q2[24:13];
  end

  // Stage 1 capture; bubbles in when advancing without a grant.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_q3_d    = s1_q3_q;
    s1_id_d    = s1_id_q;
    if (adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_x_d  = gnt_data;
        s1_q3_d = q3;
        s1_id_d = gnt_id;
      end
    end
  end

  // Remainder in 13 bits, then at most two conditional subtracts.
  always_comb begin
    q3q   = {12'b0, s1_q3_q} * 24'(Q);
    r     = s1_x_q[12:0] - q3q[12:0];
    r_sub = r;
    if (r >= 13'(2 * Q))
      r_sub = r - 13'(2 * Q);
    else if (r >= 13'(Q))
      r_sub = r - 13'(Q);
    red = r_sub[11:0];
  end

  // Output register; payload only reloads behind a valid stage 1.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (adv) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_id_d   = s1_id_q;
        rsp_data_d = red;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_q3_q     <= '0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_q3_q     <= s1_q3_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Drive response port and occupancy flag.
  always_comb begin
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_id    = rsp_id_q;
    bus.rsp_data  = rsp_data_q;
    bus.busy      = s1_valid_q | rsp_valid_q;
  end

endmodule

// File: tb/tb_barret_2137_arbiter.sv
// Bench for barret_2137_arbiter: directed cases plus random
// traffic scored against a queue model of the arbiter.
module tb_barret_2137_arbiter;

  localparam int N  = 4;
  localparam int QM = 2137;

  logic clk;
  logic rst;

  barret_2137_arbiter_if #(.NUM_REQ(N), .ID_W(2)) bus();

  barret_2137_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs;
  int checks;

  logic [N-1:0] pend;
  int           pdata [N];
  int           ptr;
  int           exp_id [$];
  int           exp_val [$];
  int           n_rsp;
  logic [N-1:0] last_rdy;
  logic         hold_chk;
  logic [1:0]   prev_id;
  logic [11:0]  prev_data;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock: drive, score at negedge, return at posedge+1.
  task automatic step();
    int g;
    int idx;
    logic adv;
    logic [N-1:0] exp_rdy;
    bus.req_valid = pend;
    for (int i = 0; i < N; i++)
      bus.req_data[23*i +: 23] = 23'(pdata[i]);
    @(negedge clk);
    if (hold_chk) begin
      chk("hold_valid", 32'(bus.rsp_valid), 1);
      chk("hold_id", 32'(bus.rsp_id), 32'(prev_id));
      chk("hold_data", 32'(bus.rsp_data), 32'(prev_data));
    end
    adv = !bus.rsp_valid || bus.rsp_ready;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (g < 0 && pend[idx]) g = idx;
    end
    exp_rdy = '0;
    if (!rst && adv && g >= 0) exp_rdy = N'(1) << g;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    last_rdy = bus.req_ready;
    if (rst) begin
      exp_id.delete();
      exp_val.delete();
      ptr = 0;
      hold_chk = 1'b0;
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_id.size() == 0) begin
          chk("rsp_extra", 1, 0);
        end else begin
          chk("rsp_id", 32'(bus.rsp_id), exp_id.pop_front());
          chk("rsp_data", 32'(bus.rsp_data), exp_val.pop_front());
          n_rsp++;
        end
      end
      if (adv && g >= 0) begin
        exp_id.push_back(g);
        exp_val.push_back(pdata[g] % QM);
        pend[g] = 1'b0;
        ptr = (g + 1) % N;
      end
      hold_chk  = bus.rsp_valid && !bus.rsp_ready;
      prev_id   = bus.rsp_id;
      prev_data = bus.rsp_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    pend = '0;
    step();
    rst  = 1'b0;
  endtask

  // Lone request on port id; checks latency and value directly.
  task automatic single(input int id, input int val, input int exp);
    pend[id]  = 1'b1;
    pdata[id] = val;
    step();
    chk("lat_v0", 32'(bus.rsp_valid), 0);
    chk("lat_busy", 32'(bus.busy), 1);
    step();
    chk("lat_v1", 32'(bus.rsp_valid), 1);
    chk("lat_id", 32'(bus.rsp_id), 32'(id));
    chk("lat_data", 32'(bus.rsp_data), 32'(exp));
    step();
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    pend = '0;
    bus.rsp_ready = 1'b1;
    while ((exp_id.size() != 0 || bus.busy) && c < budget) begin
      step();
      c++;
    end
    chk("drain_left", 32'(exp_id.size()), 0);
  endtask

  int t2_in  [6] = '{0, 2137, 2136, 4566768, 4274, 4275};
  int t2_exp [6] = '{0, 0, 2136, 2136, 0, 1};

  initial begin
    int base;
    int c;
    errs     = 0;
    checks   = 0;
    pend     = '0;
    ptr      = 0;
    n_rsp    = 0;
    hold_chk = 1'b0;
    last_rdy = '0;
    prev_id  = '0;
    prev_data = '0;
    for (int i = 0; i < N; i++) pdata[i] = 0;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(bus.rsp_valid), 0);
    chk("rst_id", 32'(bus.rsp_id), 0);
    chk("rst_data", 32'(bus.rsp_data), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);

    // T1 single
    single(0, 5000, 726);

    // T2 bounds across ports
    for (int i = 0; i < 6; i++)
      single(i % N, t2_in[i], t2_exp[i]);

    // T3 fairness with every port asking
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          pend[i]  = 1'b1;
          pdata[i] = $urandom_range(0, QM*QM-1);
        end
      end
      step();
      chk("t3_rr", 32'(last_rdy), 32'(N'(1) << (k % N)));
    end
    drain(10);

    // T4 backpressure with three ops queued
    do_reset();
    base = n_rsp;
    bus.rsp_ready = 1'b0;
    pend = 4'b0111;
    pdata[0] = 11111;
    pdata[1] = 2222222;
    pdata[2] = 4000000;
    c = 0;
    while (!bus.rsp_valid && c < 10) begin
      step();
      c++;
    end
    chk("t4_filled", 32'(bus.rsp_valid), 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_rdy", 32'(last_rdy), 0);
    end
    bus.rsp_ready = 1'b1;
    c = 0;
    while ((pend != '0 || exp_id.size() != 0) && c < 20) begin
      step();
      c++;
    end
    chk("t4_count", 32'(n_rsp - base), 3);

    // T5 reset with two ops in flight
    do_reset();
    bus.rsp_ready = 1'b0;
    pend[0] = 1'b1;
    pdata[0] = 100;
    step();
    pend[1] = 1'b1;
    pdata[1] = 200;
    step();
    chk("t5_busy", 32'(bus.busy), 1);
    chk("t5_full", 32'(bus.rsp_valid), 1);
    do_reset();
    chk("t5_valid", 32'(bus.rsp_valid), 0);
    chk("t5_idle", 32'(bus.busy), 0);
    bus.rsp_ready = 1'b1;
    pend = '1;
    for (int i = 0; i < N; i++) pdata[i] = 300 + i;
    step();
    chk("t5_ptr", 32'(last_rdy), 1);
    drain(20);

    // T6 random traffic
    for (int k = 0; k < 10000; k++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]  = 1'b1;
          pdata[i] = $urandom_range(0, QM*QM-1);
        end
      end
      step();
    end
    c = 0;
    bus.rsp_ready = 1'b1;
    while (pend != '0 && c < 20) begin
      step();
      c++;
    end
    chk("t6_pend", 32'(pend), 0);
    drain(20);
    chk("t6_idle", 32'(bus.busy), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
